// File: rtl/rv32_pkg.sv
// RV32I shared definitions: opcodes, funct codes, ALU/immediate enums
// and the combinational helpers used by the core.
package rv32_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_sel_t;

  function automatic alu_op_t alu_dec(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_t op;
    unique case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] imm_gen(
    input imm_sel_t    s,
    input logic [31:0] i
  );
    logic [31:0] r;
    unique case (s)
      IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   r = {{19{i[31]}}, i[31], i[7],
                    i[30:25], i[11:8], 1'b0};
      IMM_U:   r = {i[31:12], 12'b0};
      IMM_J:   r = {{11{i[31]}}, i[31], i[19:12],
                    i[20], i[30:21], 1'b0};
      default: r = {{20{i[31]}}, i[31:20]};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] alu_f(
    input alu_op_t     op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] y;
    unique case (op)
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $signed(a) >>> b[4:0];
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
    return y;
  endfunction

  function automatic logic br_taken(
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic t;
    unique case (f3)
      F3_BEQ:  t = (a == b);
      F3_BNE:  t = (a != b);
      F3_BLT:  t = ($signed(a) < $signed(b));
      F3_BGE:  t = !($signed(a) < $signed(b));
      F3_BLTU: t = (a < b);
      F3_BGEU: t = !(a < b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rv32_cpu_top_verify_if.sv
// Instruction-fetch bus: the core drives the PC, memory returns
// the instruction word combinationally.
interface rv32_cpu_top_verify_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_out;

  modport master (output imem_addr, input imem_out);
  modport slave  (input imem_addr, output imem_out);
endinterface

// File: rtl/rv32_regfile.sv
// 32x32 register file: two operand reads, one debug read,
// one synchronous write, async active-low clear.
module rv32_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  ra3,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] rd3,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] mem_q [32];

  // Entry 0 is cleared on reset and never written, so x0 reads 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (we && wa != 5'd0) begin
      mem_q[wa] <= wd;
    end
  end

  assign rd1 = mem_q[ra1];
  assign rd2 = mem_q[ra2];
  assign rd3 = mem_q[ra3];
endmodule

// File: rtl/rv32_cpu_top_verify.sv
// Single-cycle RV32I core (ALU, LUI/AUIPC, branches, jumps).
// Define CPU_TRAP_ILLEGAL_EN to halt on illegal opcodes.
module rv32_cpu_top_verify
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  rv32_cpu_top_verify_if.master        imem,
  input  logic [4:0]                   ra3,
  output logic [31:0]                  rd3,
  output logic                         illegal
);
`ifdef CPU_TRAP_ILLEGAL_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic [31:0] pc_q, pc_d, pc_4, nxt_pc;
  logic [31:0] instr, imm, rs1_v, rs2_v;
  logic [31:0] op_a, op_b, alu_y, wd;
  logic        illegal_q, illegal_d, halt;
  logic        we, bad, a_pc, a_zero, b_imm;
  logic        is_jal, is_jalr, is_br;
  logic [6:0]  opc;
  logic [2:0]  f3;
  imm_sel_t    imm_sel;
  alu_op_t     alu_op;

  assign instr = imem.imem_out;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];

  always_comb begin
    imm_sel = IMM_I;
    alu_op  = ALU_ADD;
    we      = 1'b0;
    bad     = 1'b0;
    a_pc    = 1'b0;
    a_zero  = 1'b0;
    b_imm   = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    is_br   = 1'b0;
    unique case (1'b1)
      opc == OP: begin
        alu_op = alu_dec(f3, instr[30]);
        we     = 1'b1;
      end
      opc == OP_IMM: begin
        alu_op = alu_dec(f3, f3 == F3_SR && instr[30]);
        b_imm  = 1'b1;
        we     = 1'b1;
      end
      opc == LUI: begin
        imm_sel = IMM_U;
        a_zero  = 1'b1;
        b_imm   = 1'b1;
        we      = 1'b1;
      end
      opc == AUIPC: begin
        imm_sel = IMM_U;
        a_pc    = 1'b1;
        b_imm   = 1'b1;
        we      = 1'b1;
      end
      opc == JAL: begin
        imm_sel = IMM_J;
        a_pc    = 1'b1;
        b_imm   = 1'b1;
        is_jal  = 1'b1;
        we      = 1'b1;
      end
      opc == JALR: begin
        b_imm   = 1'b1;
        is_jalr = 1'b1;
        we      = 1'b1;
      end
      opc == BRANCH: begin
        imm_sel = IMM_B;
        is_br   = 1'b1;
      end
      opc == LOAD, opc == STORE,
      opc == MISC_MEM, opc == SYSTEM: ;
      default: bad = 1'b1;
    endcase
  end

  assign imm   = imm_gen(imm_sel, instr);
  assign op_a  = a_zero ? '0 : (a_pc ? pc_q : rs1_v);
  assign op_b  = b_imm ? imm : rs2_v;
  assign alu_y = alu_f(alu_op, op_a, op_b);
  assign pc_4  = pc_q + 32'd4;
  assign wd    = (is_jal || is_jalr) ? pc_4 : alu_y;

  always_comb begin
    nxt_pc = pc_4;
    if (is_jal)
      nxt_pc = alu_y;
    else if (is_jalr)
      nxt_pc = alu_y & ~32'd1;
    else if (is_br && br_taken(f3, rs1_v, rs2_v))
      nxt_pc = pc_q + imm;
  end

  // Without the trap build these fold to constant 0.
  assign halt      = TRAP & (illegal_q | bad);
  assign illegal_d = TRAP & (illegal_q | bad);
  assign pc_d      = halt ? pc_q : nxt_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign illegal        = illegal_q;

  rv32_regfile u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (instr[19:15]),
    .ra2 (instr[24:20]),
    .ra3 (ra3),
    .rd1 (rs1_v),
    .rd2 (rs2_v),
    .rd3 (rd3),
    .we  (we & ~halt),
    .wa  (instr[11:7]),
    .wd  (wd)
  );
endmodule

// File: tb/tb_rv32_cpu_top_verify.sv
// Directed bench for rv32_cpu_top_verify with an expectation
// queue drained after each program run.
module tb_rv32_cpu_top_verify;
  typedef enum int {K_REG, K_PC, K_ILL} kind_t;
  typedef struct {
    string       tag;
    kind_t       kind;
    logic [4:0]  idx;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  ra3 = 5'd0;
  logic [31:0] rd3;
  logic        illegal;
  logic [31:0] mem [64];
  exp_t        sb [$];
  int          n_chk = 0;
  int          n_fail = 0;

  rv32_cpu_top_verify_if imem_bus ();
  assign imem_bus.imem_out = mem[imem_bus.imem_addr[7:2]];

  rv32_cpu_top_verify #(.RESET_PC(32'h0)) dut (
    .clk     (clk),
    .rst     (rst),
    .imem    (imem_bus),
    .ra3     (ra3),
    .rd3     (rd3),
    .illegal (illegal)
  );

  always #50 clk = ~clk;

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
  endtask

  task automatic put(input int a, input logic [31:0] w);
    mem[a] = w;
  endtask

  task automatic start();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_v(input string tag, input kind_t k,
                          input logic [4:0] idx,
                          input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.kind = k;
    e.idx = idx;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ra3 = e.idx;
      #1;
      case (e.kind)
        K_REG:   obs = rd3;
        K_PC:    obs = imem_bus.imem_addr;
        default: obs = {31'b0, illegal};
      endcase
      n_chk++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h",
               e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    clear_mem();
    put(0, 32'h0010_0093);
    put(1, 32'h0020_8113);
    put(2, 32'h0020_81b3);
    #10;
    expect_v("por_pc", K_PC, 5'd0, 32'h0);
    expect_v("por_x5", K_REG, 5'd5, 32'h0);
    drain();

    start();
    run(3);
    expect_v("addpos_x1", K_REG, 5'd1, 32'h1);
    expect_v("addpos_x2", K_REG, 5'd2, 32'h3);
    expect_v("addpos_x3", K_REG, 5'd3, 32'h4);
    expect_v("addpos_pc", K_PC, 5'd0, 32'hC);
    drain();

    @(posedge clk);
    #20;
    rst = 1'b0;
    #1;
    expect_v("rst_pc", K_PC, 5'd0, 32'h0);
    for (int r = 0; r < 32; r++)
      expect_v($sformatf("rst_x%0d", r), K_REG, r[4:0], 32'h0);
    drain();
    @(negedge clk);
    rst = 1'b1;

    clear_mem();
    put(0, 32'hfff0_0093);
    put(1, 32'h0010_0113);
    put(2, 32'h0020_81b3);
    start();
    run(3);
    expect_v("wrap_x1", K_REG, 5'd1, 32'hFFFF_FFFF);
    expect_v("wrap_x3", K_REG, 5'd3, 32'h0);
    drain();

    clear_mem();
    put(0, 32'h0000_0093);
    put(1, 32'hfff0_0113);
    put(2, 32'h0020_81b3);
    start();
    run(3);
    expect_v("neg_x3", K_REG, 5'd3, 32'hFFFF_FFFF);
    drain();

    clear_mem();
    put(0, 32'h0050_0013);
    start();
    run(1);
    expect_v("x0_rd", K_REG, 5'd0, 32'h0);
    expect_v("x0_pc", K_PC, 5'd0, 32'h4);
    drain();

    clear_mem();
    put(0, 32'h0080_00ef);
    put(2, 32'hfe00_0ce3);
    start();
    run(1);
    expect_v("jal_pc", K_PC, 5'd0, 32'h8);
    expect_v("jal_x1", K_REG, 5'd1, 32'h4);
    drain();
    run(1);
    expect_v("beq_pc", K_PC, 5'd0, 32'h0);
    drain();

    clear_mem();
    put(0, 32'h1234_52b7);
    put(1, 32'h0000_1317);
    put(2, 32'hff00_0093);
    put(3, 32'h4020_d113);
    put(4, 32'h01c0_d193);
    put(5, 32'h0020_a233);
    put(6, 32'h0210_0467);
    put(8, 32'h0000_1463);
    start();
    run(8);
    expect_v("lui_x5", K_REG, 5'd5, 32'h1234_5000);
    expect_v("auipc_x6", K_REG, 5'd6, 32'h0000_1004);
    expect_v("addi_x1", K_REG, 5'd1, 32'hFFFF_FFF0);
    expect_v("srai_x2", K_REG, 5'd2, 32'hFFFF_FFFC);
    expect_v("srli_x3", K_REG, 5'd3, 32'h0000_000F);
    expect_v("slt_x4", K_REG, 5'd4, 32'h1);
    expect_v("jalr_x8", K_REG, 5'd8, 32'h1C);
    expect_v("bne_pc", K_PC, 5'd0, 32'h24);
    drain();

    clear_mem();
    put(0, 32'h0000_007f);
    put(1, 32'h0010_0093);
    start();
    run(2);
`ifdef CPU_TRAP_ILLEGAL_EN
    expect_v("ill_flag", K_ILL, 5'd0, 32'h1);
    expect_v("ill_pc", K_PC, 5'd0, 32'h0);
    expect_v("ill_x1", K_REG, 5'd1, 32'h0);
`else
    expect_v("ill_flag", K_ILL, 5'd0, 32'h0);
    expect_v("ill_pc", K_PC, 5'd0, 32'h8);
    expect_v("ill_x1", K_REG, 5'd1, 32'h1);
`endif
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
